// File: rtl/scanline_pos_gen.sv
// scanline_pos_gen: per-line fractional source position, cycle-aligned with the delayed video/sync bus.
// Optional feature macro SL_POS_FIELD_OFS_EN: odd fields start half an output-line step lower.
`ifndef VDATA_O_CO_SLICE
`define VDATA_O_CO_SLICE 23:0
`endif

module scanline_pos_gen #(
    parameter int ACC_INT_WIDTH = 4,
    parameter int PIPE_DELAY    = 2
) (
    input  logic                         VCLK_i,
    input  logic                         nVRST_i,
    input  logic                         HSYNC_i,
    input  logic                         VSYNC_i,
    input  logic                         DE_i,
    input  logic [`VDATA_O_CO_SLICE]     vdata_i,
    input  logic [ACC_INT_WIDTH+7:0]     v_step_i,
    input  logic [7:0]                   v_offset_i,
    input  logic                         field_i,
    output logic                         HSYNC_o,
    output logic                         VSYNC_o,
    output logic                         DE_o,
    output logic [`VDATA_O_CO_SLICE]     vdata_o,
    output logic [7:0]                   sl_rel_pos_o,
    output logic                         frame_start_o
);
    localparam int AW = ACC_INT_WIDTH + 8;

    logic                     r_vs_q;
    logic                     r_de_q;
    logic [AW-1:0]            r_acc;
    logic [AW-1:0]            r_step_l;
    logic [PIPE_DELAY-1:0]    r_hs;
    logic [PIPE_DELAY-1:0]    r_vs;
    logic [PIPE_DELAY-1:0]    r_de;
    logic [PIPE_DELAY-1:0]    r_fs;
    logic [`VDATA_O_CO_SLICE] r_vd  [PIPE_DELAY];
    logic [7:0]               r_pos [PIPE_DELAY];

    logic                     w_vs_fall;
    logic                     w_de_rise;
    logic                     w_de_fall;
    logic [AW-1:0]            w_start;

    assign w_vs_fall = ~VSYNC_i & r_vs_q;
    assign w_de_rise = DE_i & ~r_de_q;
    assign w_de_fall = ~DE_i & r_de_q;

`ifdef SL_POS_FIELD_OFS_EN
    assign w_start = {{ACC_INT_WIDTH{1'b0}}, v_offset_i} + (field_i ? (v_step_i >> 1) : '0);
`else
    logic w_unused_field;
    assign w_unused_field = field_i;
    assign w_start = {{ACC_INT_WIDTH{1'b0}}, v_offset_i};
`endif

    // Edge-detect history, per-frame step latch and the line position accumulator
    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            r_vs_q   <= 1'b0;
            r_de_q   <= 1'b0;
            r_acc    <= '0;
            r_step_l <= '0;
        end else begin
            r_vs_q <= VSYNC_i;
            r_de_q <= DE_i;
            if (w_vs_fall) begin
                r_acc    <= w_start;
                r_step_l <= v_step_i;
            end else if (w_de_fall) begin
                r_acc <= r_acc + r_step_l;
            end
        end
    end

    // Sync/DE/frame-start delay lines; syncs flush to their inactive-high level
    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            r_hs <= '1;
            r_vs <= '1;
            r_de <= '0;
            r_fs <= '0;
        end else begin
            r_hs <= {r_hs[PIPE_DELAY-2:0], HSYNC_i};
            r_vs <= {r_vs[PIPE_DELAY-2:0], VSYNC_i};
            r_de <= {r_de[PIPE_DELAY-2:0], DE_i};
            r_fs <= {r_fs[PIPE_DELAY-2:0], w_vs_fall};
        end
    end

    // Pixel delay line
    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            for (int k = 0; k < PIPE_DELAY; k++) r_vd[k] <= '0;
        end else begin
            r_vd[0] <= vdata_i;
            for (int k = 1; k < PIPE_DELAY; k++) r_vd[k] <= r_vd[k-1];
        end
    end

    // Position capture at line start; the first stage holds through blanking, the rest align it with DE_o
    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            for (int k = 0; k < PIPE_DELAY; k++) r_pos[k] <= '0;
        end else begin
            r_pos[0] <= w_de_rise ? (w_vs_fall ? w_start[7:0] : r_acc[7:0]) : r_pos[0];
            for (int k = 1; k < PIPE_DELAY; k++) r_pos[k] <= r_pos[k-1];
        end
    end

    assign HSYNC_o       = r_hs[PIPE_DELAY-1];
    assign VSYNC_o       = r_vs[PIPE_DELAY-1];
    assign DE_o          = r_de[PIPE_DELAY-1];
    assign frame_start_o = r_fs[PIPE_DELAY-1];
    assign vdata_o       = r_vd[PIPE_DELAY-1];
    assign sl_rel_pos_o  = r_pos[PIPE_DELAY-1];

endmodule

// File: tb/tb_scanline_pos_gen.sv
// tb_scanline_pos_gen: randomized line/frame stimulus checked against a closed-form position model.
`ifndef VDATA_O_CO_SLICE
`define VDATA_O_CO_SLICE 23:0
`endif

module tb_scanline_pos_gen;
    localparam int PD = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     hs_i, vs_i, de_i, fld_i;
    logic [`VDATA_O_CO_SLICE] vd_i;
    logic [11:0]              step_i;
    logic [7:0]               off_i;
    logic                     hs_o, vs_o, de_o, fs_o;
    logic [`VDATA_O_CO_SLICE] vd_o;
    logic [7:0]               pos_o;

    localparam int VW = $bits(vd_i);

    scanline_pos_gen #(.ACC_INT_WIDTH(4), .PIPE_DELAY(PD)) dut (
        .VCLK_i(clk), .nVRST_i(rst_n), .HSYNC_i(hs_i), .VSYNC_i(vs_i), .DE_i(de_i),
        .vdata_i(vd_i), .v_step_i(step_i), .v_offset_i(off_i), .field_i(fld_i),
        .HSYNC_o(hs_o), .VSYNC_o(vs_o), .DE_o(de_o), .vdata_o(vd_o),
        .sl_rel_pos_o(pos_o), .frame_start_o(fs_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: history of inputs plus the position each line should report
    int                       cyc = 0;
    logic                     h_hs [8], h_vs [8], h_de [8], h_fs [8];
    logic [`VDATA_O_CO_SLICE] h_vd [8];
    logic [7:0]               h_pos [8];
    int                       m_start = 0, m_step = 0, n_ln = 0;
    logic [7:0]               m_pos = 0;
    logic                     p_vs = 0, p_de = 0;

    always @(posedge clk) begin
        int i;
        bit vsf, dr, df;
        cyc++;
        i = cyc & 7;
        if (!rst_n) begin
            m_start = 0; m_step = 0; n_ln = 0; m_pos = 0; p_vs = 0; p_de = 0;
            h_hs[i] = 1; h_vs[i] = 1; h_de[i] = 0; h_fs[i] = 0; h_vd[i] = '0; h_pos[i] = 0;
        end else begin
            vsf = !vs_i && p_vs;
            dr  = de_i && !p_de;
            df  = !de_i && p_de;
            if (vsf) begin
                m_start = int'(off_i);
`ifdef SL_POS_FIELD_OFS_EN
                if (fld_i) m_start += int'(step_i) / 2;
`endif
                m_step = int'(step_i);
                n_ln   = 0;
            end else if (df) begin
                n_ln++;
            end
            if (dr) m_pos = 8'(m_start + n_ln * m_step);
            h_hs[i] = hs_i; h_vs[i] = vs_i; h_de[i] = de_i; h_vd[i] = vd_i;
            h_fs[i] = vsf; h_pos[i] = m_pos;
            p_vs = vs_i; p_de = de_i;
        end
    end

    // Output checker, sampled on the falling edge
    logic [7:0] cap [$];
    int         fs_cnt = 0;
    logic       p_deo = 0;
    int         j;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_hs", hs_o, 1); chk("rst_vs", vs_o, 1); chk("rst_de", de_o, 0);
            chk("rst_vd", vd_o, 0); chk("rst_pos", pos_o, 0); chk("rst_fs", fs_o, 0);
        end else begin
            j = (cyc - PD + 1) & 7;
            chk("hs", hs_o, h_hs[j]); chk("vs", vs_o, h_vs[j]); chk("de", de_o, h_de[j]);
            chk("vd", vd_o, h_vd[j]); chk("fs", fs_o, h_fs[j]); chk("pos", pos_o, h_pos[j]);
        end
        if (de_o && !p_deo) cap.push_back(pos_o);
        if (fs_o) fs_cnt++;
        p_deo = de_o;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); de_i = 0; hs_i = 1; vd_i = '0;
        end
    endtask

    task automatic line(input int w, input bit vs_end);
        repeat (w) begin
            @(negedge clk); de_i = 1; hs_i = 1; vd_i = VW'($urandom());
        end
        @(negedge clk); de_i = 0; vd_i = '0;
        if (vs_end) vs_i = 0;
        @(negedge clk); hs_i = 0;
        @(negedge clk); hs_i = 0;
        @(negedge clk); hs_i = 1;
        idle($urandom_range(0, 2));
    endtask

    task automatic frame(input logic [11:0] s, input logic [7:0] o, input bit f,
                         input int nl, input int ca, input logic [11:0] s2);
        step_i = s; off_i = o; fld_i = f;
        @(negedge clk); vs_i = 0;
        idle(2);
        @(negedge clk); vs_i = 1;
        idle(1);
        for (int i = 0; i < nl; i++) begin
            if (i == ca) begin
                step_i = s2; off_i = ~o; fld_i = ~f;
            end
            line($urandom_range(3, 8), 1'b0);
        end
    endtask

    task automatic chk_cap(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_n"}, (cap.size() >= 4) ? 1 : 0, 1);
        for (int k = 0; k < 4 && k < cap.size(); k++) chk(tag, cap[k], e[k]);
    endtask

    initial begin
        rst_n = 0; hs_i = 1; vs_i = 1; de_i = 0; vd_i = '0; step_i = 0; off_i = 0; fld_i = 0;
        idle(5);
        @(negedge clk); rst_n = 1;
        idle(3);
        // 2x scale
        cap.delete();
        frame(12'h080, 8'h40, 0, 4, 4, 0);
        idle(3);
        chk_cap("cap2x", 8'h40, 8'hC0, 8'h40, 8'hC0);
        // 4.5x-ish scale with wrap
        cap.delete();
        frame(12'h039, 8'h00, 0, 6, 6, 0);
        idle(3);
        chk_cap("cap45a", 8'h00, 8'h39, 8'h72, 8'hAB);
        chk("cap45b", (cap.size() == 6) ? {24'h0, cap[4], cap[5]} : 0, 32'hE41D);
        // Mid-frame step change is deferred to the next frame
        cap.delete();
        frame(12'h080, 8'h10, 0, 5, 2, 12'h100);
        idle(3);
        chk_cap("capchg", 8'h10, 8'h90, 8'h10, 8'h90);
        cap.delete();
        frame(12'h100, 8'h30, 0, 2, 2, 0);
        idle(3);
        chk("capnext_n", cap.size(), 2);
        // VSYNC fall coincident with DE fall
        cap.delete();
        frame(12'h080, 8'h40, 0, 1, 1, 0);
        off_i = 8'h20;
        fs_cnt = 0;
        line(5, 1'b1);
        @(negedge clk); vs_i = 1;
        line(4, 1'b0);
        line(4, 1'b0);
        idle(3);
        chk_cap("capcoin", 8'h40, 8'hC0, 8'h20, 8'hA0);
        chk("fs_once", fs_cnt, 1);
`ifdef SL_POS_FIELD_OFS_EN
        cap.delete();
        frame(12'h080, 8'h00, 1, 4, 4, 0);
        idle(3);
        chk_cap("capodd", 8'h40, 8'hC0, 8'h40, 8'hC0);
        cap.delete();
        frame(12'h080, 8'h00, 0, 4, 4, 0);
        idle(3);
        chk_cap("capeven", 8'h00, 8'h80, 8'h00, 8'h80);
`endif
        // Asynchronous reset mid-line
        repeat (3) begin
            @(negedge clk); de_i = 1; vd_i = VW'($urandom());
        end
        #2 rst_n = 0;
        #1;
        chk("arst_hs", hs_o, 1); chk("arst_vs", vs_o, 1); chk("arst_de", de_o, 0);
        chk("arst_vd", vd_o, 0); chk("arst_pos", pos_o, 0);
        idle(5);
        @(negedge clk); rst_n = 1;
        cap.delete();
        step_i = 12'h055; off_i = 8'h33;
        line(4, 1'b0);
        line(4, 1'b0);
        idle(3);
        chk("prevs_n", cap.size(), 2);
        chk("prevs_pos", (cap.size() == 2) ? {24'h0, cap[0], cap[1]} : 1, 0);
        // Randomized frames, some ending with a coincident VSYNC/DE fall
        repeat (12) begin
            frame(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  $urandom_range(2, 6), $urandom_range(1, 6), 12'($urandom_range(0, 4095)));
            if ($urandom_range(0, 2) == 0) begin
                off_i = 8'($urandom_range(0, 255));
                line($urandom_range(3, 8), 1'b1);
                @(negedge clk); vs_i = 1;
                line($urandom_range(3, 8), 1'b0);
                line($urandom_range(3, 8), 1'b0);
            end
        end
        idle(6);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
